fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_arb_pkg.sv | 15 +
 rtl/rr_picker.sv | 41 ++++
 rtl/fifo_wr_arbiter.sv | 97 +++++++++
 tb/tb_fifo_wr_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write arbiter.
// No logic of its own; imported by the arbiter top and its picker.
// Holds no state, so there is no backpressure to describe.
package fifo_arb_pkg;

    localparam int DEF_FIFO_WIDTH = 16;
    localparam int DEF_NUM_REQ    = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set req bit after last_winner, wrapping.
// Zero latency; purely combinational.
// No backpressure; valid simply reports that any req bit is set.
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_winner,
    output logic               valid,
    output logic [IDX_W-1:0]   winner
);

    logic [NUM_REQ-1:0] upper_mask;
    logic [NUM_REQ-1:0] masked_req;

    always_comb begin
        upper_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            upper_mask[i] = (i > int'(last_winner));
        end
        masked_req = req & upper_mask;
        valid      = |req;
        winner     = '0;
        // Unmasked scan first, then the masked scan overrides it when anything
        // above last_winner is pending, giving the wrap-around order.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                winner = IDX_W'(i);
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (masked_req[i]) begin
                winner = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter for NUM_REQ writers into one FIFO; FIFO_ARB_PRIO0_EN gives requester 0 strict priority.
// One cycle from decision edge to registered gnt/fifo_wr_en/fifo_data_in; one write per cycle max.
// Grants stall (HOLD) while the FIFO is full, or almost full with a write already in flight.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int NUM_REQ    = DEF_NUM_REQ
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_REQ-1:0]                  req,
    input  logic [NUM_REQ-1:0][FIFO_WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]                  gnt,
    output logic                                fifo_wr_en,
    output logic [FIFO_WIDTH-1:0]               fifo_data_in,
    input  logic                                fifo_full,
    input  logic                                fifo_almostfull,
    input  logic                                fifo_wr_ack,
    input  logic                                fifo_overflow,
    output logic                                ack_err,
    output logic                                ovf_err,
    output logic                                busy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t        state;
    logic [IDX_W-1:0]  last_winner;
    logic [IDX_W-1:0]  rr_winner;
    logic [IDX_W-1:0]  pick;
    logic              any_req;
    logic              space_safe;
    logic              wr_d;

    rr_picker #(
        .NUM_REQ     (NUM_REQ)
    ) u_rr_picker (
        .req         (req),
        .last_winner (last_winner),
        .valid       (any_req),
        .winner      (rr_winner)
    );

    // A write issued last cycle has not yet shown up in the FIFO flags.
    assign space_safe = !fifo_full && !(fifo_wr_en && fifo_almostfull);

`ifdef FIFO_ARB_PRIO0_EN
    assign pick = req[0] ? '0 : rr_winner;
`else
    assign pick = rr_winner;
`endif

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            last_winner  <= IDX_W'(NUM_REQ - 1);
            gnt          <= '0;
            fifo_wr_en   <= 1'b0;
            fifo_data_in <= '0;
        end else begin
            gnt        <= '0;
            fifo_wr_en <= 1'b0;
            if (!any_req) begin
                state <= ST_IDLE;
            end else if (space_safe) begin
                state        <= ST_ISSUE;
                gnt          <= NUM_REQ'(1) << pick;
                fifo_wr_en   <= 1'b1;
                fifo_data_in <= req_data[pick];
                last_winner  <= pick;
            end else begin
                state <= ST_HOLD;
            end
        end
    end

    // Sticky error flags; wr_d remembers last cycle's write so the ack can be checked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_d    <= 1'b0;
            ack_err <= 1'b0;
            ovf_err <= 1'b0;
        end else begin
            wr_d <= fifo_wr_en;
            if (wr_d && !fifo_wr_ack) begin
                ack_err <= 1'b1;
            end
            if (fifo_overflow) begin
                ovf_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter with a behavioural depth-8 FIFO model.
module tb_fifo_wr_arbiter;

    localparam int W     = 16;
    localparam int N     = 4;
    localparam int DEPTH = 8;

    typedef struct {
        logic [N-1:0] g;
        logic [W-1:0] d;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [N-1:0]        req;
    logic [N-1:0][W-1:0] req_data;
    logic [N-1:0]        gnt;
    logic                fifo_wr_en;
    logic [W-1:0]        fifo_data_in;
    logic                fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow;
    logic                ack_err, ovf_err, busy;

    logic bypass, fifo_clr, fifo_rd, ack_kill, ovf_force, mdl_ovf;
    int   fcount;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];
    exp_t e;
    int   writes;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.FIFO_WIDTH(W), .NUM_REQ(N)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .gnt(gnt),
        .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in),
        .fifo_full(fifo_full), .fifo_almostfull(fifo_almostfull),
        .fifo_wr_ack(fifo_wr_ack), .fifo_overflow(fifo_overflow),
        .ack_err(ack_err), .ovf_err(ovf_err), .busy(busy)
    );

    // FIFO model: bypass makes it bottomless, ack_kill suppresses the write ack.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcount      <= 0;
            fifo_wr_ack <= 1'b0;
            mdl_ovf     <= 1'b0;
        end else begin
            fifo_wr_ack <= fifo_wr_en && !ack_kill && (bypass || fcount < DEPTH);
            mdl_ovf     <= fifo_wr_en && !bypass && (fcount == DEPTH);
            if (fifo_clr || bypass)
                fcount <= 0;
            else
                fcount <= fcount + ((fifo_wr_en && fcount < DEPTH) ? 1 : 0)
                                 - ((fifo_rd && fcount > 0) ? 1 : 0);
        end
    end

    assign fifo_full       = !bypass && (fcount == DEPTH);
    assign fifo_almostfull = !bypass && (fcount >= DEPTH - 1);
    assign fifo_overflow   = mdl_ovf || ovf_force;

    function automatic exp_t mk(input int idx);
        exp_t x;
        x.g = N'(1) << idx;
        x.d = req_data[idx];
        return x;
    endfunction

    task automatic test_reset();
        #1;
        n_cmp++; if (gnt !== '0) begin n_bad++; $display("FAIL reset_gnt got=%b want=0", gnt); end
        n_cmp++; if (fifo_wr_en !== 1'b0 || fifo_data_in !== '0) begin n_bad++;
            $display("FAIL reset_wr got wr_en=%b data=%h want 0/0", fifo_wr_en, fifo_data_in); end
        n_cmp++; if ({ack_err, ovf_err, busy} !== 3'b000) begin n_bad++;
            $display("FAIL reset_flags got ack/ovf/busy=%b want 000", {ack_err, ovf_err, busy}); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        bypass = 1'b1;
        @(negedge clk);
        req = 4'b1111;
        sb.push_back(mk(0)); sb.push_back(mk(1)); sb.push_back(mk(2));
        sb.push_back(mk(3)); sb.push_back(mk(0));
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++;
            if (!fifo_wr_en || sb.size() == 0) begin n_bad++;
                $display("FAIL rr_write cycle=%0d got wr_en=%b pending=%0d want a write", c, fifo_wr_en, sb.size()); end
            else begin
                e = sb.pop_front();
                if (gnt !== e.g || fifo_data_in !== e.d) begin n_bad++;
                    $display("FAIL rr_grant cycle=%0d got gnt=%b data=%h want gnt=%b data=%h", c, gnt, fifo_data_in, e.g, e.d); end
            end
            n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rr_busy got=%b want=1", busy); end
        end
        req = '0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || fifo_wr_en !== 1'b0) begin n_bad++;
            $display("FAIL rr_idle got busy=%b wr_en=%b want 0/0", busy, fifo_wr_en); end
        n_cmp++; if (ack_err !== 1'b0) begin n_bad++; $display("FAIL rr_ack_err got=%b want=0", ack_err); end
    endtask

    task automatic test_fifo_fill();
        bypass = 1'b0;
        @(negedge clk);
        req = 4'b0001;
        for (int i = 0; i < DEPTH; i++) sb.push_back(mk(0));
        writes = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (fifo_wr_en) begin
                writes++;
                n_cmp++;
                if (sb.size() == 0) begin n_bad++; $display("FAIL fill_extra cycle=%0d got extra write want none", c); end
                else begin
                    e = sb.pop_front();
                    if (gnt !== e.g || fifo_data_in !== e.d) begin n_bad++;
                        $display("FAIL fill_grant got gnt=%b data=%h want gnt=%b data=%h", gnt, fifo_data_in, e.g, e.d); end
                end
            end
        end
        n_cmp++; if (writes != DEPTH) begin n_bad++; $display("FAIL fill_count got=%0d want=%0d", writes, DEPTH); end
        n_cmp++; if (busy !== 1'b1 || fifo_wr_en !== 1'b0) begin n_bad++;
            $display("FAIL fill_hold got busy=%b wr_en=%b want 1/0", busy, fifo_wr_en); end
        n_cmp++; if (ovf_err !== 1'b0) begin n_bad++; $display("FAIL fill_ovf got=%b want=0", ovf_err); end
    endtask

    task automatic test_hold_release();
        fifo_rd = 1'b1;
        sb.push_back(mk(0));
        writes = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            fifo_rd = 1'b0;
            if (fifo_wr_en) begin
                writes++;
                n_cmp++;
                if (sb.size() == 0) begin n_bad++; $display("FAIL hold_extra cycle=%0d got extra write want none", c); end
                else begin
                    e = sb.pop_front();
                    if (gnt !== e.g || fifo_data_in !== e.d) begin n_bad++;
                        $display("FAIL hold_grant got gnt=%b data=%h want gnt=%b data=%h", gnt, fifo_data_in, e.g, e.d); end
                    n_cmp++; if (c > 1) begin n_bad++; $display("FAIL hold_latency got cycle=%0d want <=1", c); end
                end
            end
        end
        n_cmp++; if (writes != 1) begin n_bad++; $display("FAIL hold_count got=%0d want=1", writes); end
        n_cmp++; if (busy !== 1'b1 || fifo_full !== 1'b1) begin n_bad++;
            $display("FAIL hold_rehold got busy=%b full=%b want 1/1", busy, fifo_full); end
        n_cmp++; if (ovf_err !== 1'b0) begin n_bad++; $display("FAIL hold_ovf got=%b want=0", ovf_err); end
    endtask

    task automatic test_withdraw();
        req = '0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_cmp++; if (fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL wd_write got=%b want=0", fifo_wr_en); end
        end
        n_cmp++; if ({busy, ack_err, ovf_err} !== 3'b000) begin n_bad++;
            $display("FAIL wd_flags got busy/ack/ovf=%b want 000", {busy, ack_err, ovf_err}); end
    endtask

    task automatic test_ack_err();
        fifo_clr = 1'b1;
        bypass   = 1'b1;
        @(negedge clk);
        fifo_clr = 1'b0;
        ack_kill = 1'b1;
        req      = 4'b0010;
        sb.push_back(mk(1));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            req = '0;
            if (fifo_wr_en) begin
                n_cmp++;
                if (sb.size() == 0) begin n_bad++; $display("FAIL ack_extra got extra write want none"); end
                else begin
                    e = sb.pop_front();
                    if (gnt !== e.g || fifo_data_in !== e.d) begin n_bad++;
                        $display("FAIL ack_grant got gnt=%b data=%h want gnt=%b data=%h", gnt, fifo_data_in, e.g, e.d); end
                end
            end
        end
        n_cmp++; if (ack_err !== 1'b1) begin n_bad++; $display("FAIL ack_set got=%b want=1", ack_err); end
        ack_kill = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++; if (ack_err !== 1'b1) begin n_bad++; $display("FAIL ack_sticky got=%b want=1", ack_err); end
        n_cmp++; if (ovf_err !== 1'b0) begin n_bad++; $display("FAIL ack_ovf got=%b want=0", ovf_err); end
    endtask

    task automatic test_ovf_err();
        ovf_force = 1'b1;
        @(negedge clk);
        ovf_force = 1'b0;
        n_cmp++; if (ovf_err !== 1'b1) begin n_bad++; $display("FAIL ovf_set got=%b want=1", ovf_err); end
        repeat (3) @(negedge clk);
        n_cmp++; if (ovf_err !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got=%b want=1", ovf_err); end
    endtask

    task automatic test_reset_midgrant();
        req = 4'b1111;
        sb.push_back(mk(2));
        @(negedge clk);
        n_cmp++;
        if (!fifo_wr_en || sb.size() == 0) begin n_bad++; $display("FAIL mid_write got wr_en=%b want=1", fifo_wr_en); end
        else begin
            e = sb.pop_front();
            if (gnt !== e.g) begin n_bad++; $display("FAIL mid_grant got gnt=%b want=%b", gnt, e.g); end
        end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (gnt !== '0 || fifo_wr_en !== 1'b0 || fifo_data_in !== '0) begin n_bad++;
            $display("FAIL mid_rst_out got gnt=%b wr_en=%b data=%h want zeros", gnt, fifo_wr_en, fifo_data_in); end
        n_cmp++; if ({ack_err, ovf_err, busy} !== 3'b000) begin n_bad++;
            $display("FAIL mid_rst_flags got ack/ovf/busy=%b want 000", {ack_err, ovf_err, busy}); end
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back(mk(0)); sb.push_back(mk(1));
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_cmp++;
            if (!fifo_wr_en || sb.size() == 0) begin n_bad++; $display("FAIL mid_after got wr_en=%b want=1", fifo_wr_en); end
            else begin
                e = sb.pop_front();
                if (gnt !== e.g || fifo_data_in !== e.d) begin n_bad++;
                    $display("FAIL mid_after_grant got gnt=%b data=%h want gnt=%b data=%h", gnt, fifo_data_in, e.g, e.d); end
            end
        end
        req = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if (ack_err !== 1'b0 || ovf_err !== 1'b0) begin n_bad++;
            $display("FAIL mid_no_err got ack=%b ovf=%b want 0/0", ack_err, ovf_err); end
    endtask

    task automatic test_prio0();
        req = 4'b0011;
`ifdef FIFO_ARB_PRIO0_EN
        for (int i = 0; i < 4; i++) sb.push_back(mk(0));
`else
        for (int i = 0; i < 4; i++) sb.push_back(mk(i % 2));
`endif
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_cmp++;
            if (!fifo_wr_en || sb.size() == 0) begin n_bad++; $display("FAIL prio_write got wr_en=%b want=1", fifo_wr_en); end
            else begin
                e = sb.pop_front();
                if (gnt !== e.g || fifo_data_in !== e.d) begin n_bad++;
                    $display("FAIL prio_grant cycle=%0d got gnt=%b data=%h want gnt=%b data=%h", c, gnt, fifo_data_in, e.g, e.d); end
            end
        end
        req = '0;
        repeat (2) @(negedge clk);
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL sb_drain got=%0d want=0", sb.size()); end
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        bypass    = 1'b1;
        fifo_clr  = 1'b0;
        fifo_rd   = 1'b0;
        ack_kill  = 1'b0;
        ovf_force = 1'b0;
        for (int i = 0; i < N; i++) req_data[i] = W'(16'h00A5 + 16'h1100 * i);
        test_reset();
        test_round_robin();
        test_fifo_fill();
        test_hold_release();
        test_withdraw();
        test_ack_err();
        test_ovf_err();
        test_reset_midgrant();
        test_prio0();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
